// File: rtl/riscv_retire_tracker.sv
// Commit-side retire tracker: instruction counter, result port and two-instruction halt detector.
// Define TRACE_FIFO_EN to add the TRACE_* retire-trace FIFO and its ports.
module riscv_retire_tracker #(
    parameter logic [31:0] HALT_INST0 = 32'h00c00093,
    parameter logic [31:0] HALT_INST1 = 32'h00008067
`ifdef TRACE_FIFO_EN
    ,
    parameter int unsigned TRACE_DEPTH = 8
`endif
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RET_VALID,
    input  logic [31:0] RET_INST,
    input  logic [31:0] RET_PC,
    input  logic [31:0] RET_RESULT,
    output logic [31:0] NUM_INST,
    output logic [31:0] OUTPUT_PORT,
    output logic        HALT,
`ifdef TRACE_FIFO_EN
    output logic        TRACE_VALID,
    input  logic        TRACE_READY,
    output logic [63:0] TRACE_DATA,
    output logic        TRACE_OVF,
`endif
    output logic [1:0]  DBG_STATE
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_HALTED = 2'd2
    } halt_state_e;

    halt_state_e state_q, state_d;
    logic [31:0] num_inst_q, num_inst_d;
    logic [31:0] out_q, out_d;
    logic        counted;

    // Once halted the core's retire stream is ignored entirely.
    assign counted = RET_VALID && (state_q != ST_HALTED);

    always_comb begin
        state_d    = state_q;
        num_inst_d = num_inst_q;
        out_d      = out_q;
        if (counted) begin
            num_inst_d = num_inst_q + 32'd1;
            out_d      = RET_RESULT;
            case (state_q)
                ST_IDLE: begin
                    if (RET_INST == HALT_INST0) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (RET_INST == HALT_INST1)      state_d = ST_HALTED;
                    else if (RET_INST != HALT_INST0) state_d = ST_IDLE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            num_inst_q <= 32'd0;
            out_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            num_inst_q <= num_inst_d;
            out_q      <= out_d;
        end
    end

    assign NUM_INST    = num_inst_q;
    assign OUTPUT_PORT = out_q;
    assign HALT        = (state_q == ST_HALTED);
    assign DBG_STATE   = state_q;

`ifdef TRACE_FIFO_EN
    localparam int unsigned AW = $clog2(TRACE_DEPTH);

    // Handshake: an entry transfers at a rising edge where TRACE_VALID and TRACE_READY are both 1;
    // TRACE_VALID never depends on TRACE_READY and TRACE_DATA is stable while TRACE_VALID is held.
    logic [63:0]   mem_q [TRACE_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [63:0]   data_q, data_d;
    logic          ovf_q, full, pop, push;

    assign full = (cnt_q == (AW+1)'(TRACE_DEPTH));
    assign pop  = (cnt_q != '0) && TRACE_READY;
    assign push = counted && (!full || pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        data_d   = data_q;
        // Head register: the new entry becomes head only when it lands in the slot being exposed.
        if (cnt_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) data_d = {RET_PC, RET_RESULT};
            else                                data_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            data_q   <= 64'd0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            if (counted && full && !pop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= {RET_PC, RET_RESULT};
    end

    assign TRACE_VALID = (cnt_q != '0);
    assign TRACE_DATA  = data_q;
    assign TRACE_OVF   = ovf_q;
`else
    logic unused_pc;
    assign unused_pc = ^RET_PC;
`endif

endmodule

// File: tb/tb_riscv_retire_tracker.sv
// Self-checking bench for riscv_retire_tracker: directed scenarios plus random retire streams
// compared against a queue-based reference model. Trace checks apply when TRACE_FIFO_EN is defined.
module tb_riscv_retire_tracker;

    localparam logic [31:0] I0    = 32'h00c00093;
    localparam logic [31:0] I1    = 32'h00008067;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ret_valid = 1'b0;
    logic [31:0] ret_inst = '0, ret_pc = '0, ret_result = '0;
    logic        trace_ready = 1'b0;
    logic [31:0] num_inst, output_port;
    logic        halt;
    logic [1:0]  dbg_state;
`ifdef TRACE_FIFO_EN
    logic        trace_valid, trace_ovf;
    logic [63:0] trace_data;
`endif

    riscv_retire_tracker dut (
        .CLK(clk), .RST(rst), .RET_VALID(ret_valid), .RET_INST(ret_inst),
        .RET_PC(ret_pc), .RET_RESULT(ret_result),
        .NUM_INST(num_inst), .OUTPUT_PORT(output_port), .HALT(halt),
`ifdef TRACE_FIFO_EN
        .TRACE_VALID(trace_valid), .TRACE_READY(trace_ready),
        .TRACE_DATA(trace_data), .TRACE_OVF(trace_ovf),
`endif
        .DBG_STATE(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Reference model
    logic [31:0] m_cnt, m_out, m_last;
    logic        m_halt, m_ovf;
    logic [63:0] m_tdata;
    logic [63:0] exp_q[$];
    logic        rdy_g = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [31:0] inst,
                              input logic [31:0] pc, input logic [31:0] res, input logic rdy);
        logic did_pop, cnt_it;
        if (r) begin
            m_cnt = 0; m_out = 0; m_halt = 0; m_last = 0; m_ovf = 0; m_tdata = 0;
            exp_q.delete();
            return;
        end
        did_pop = (exp_q.size() > 0) && rdy;
        cnt_it  = v && !m_halt;
        if (cnt_it) begin
            m_cnt = m_cnt + 1;
            m_out = res;
            if (m_last == I0 && inst == I1) m_halt = 1'b1;
            m_last = inst;
        end
        if (did_pop) void'(exp_q.pop_front());
        if (cnt_it) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({pc, res});
            else                      m_ovf = 1'b1;
        end
        if (exp_q.size() > 0) m_tdata = exp_q[0];
    endtask

    // Driver: apply one cycle of inputs at the falling edge, check just after the rising edge.
    task automatic step(input logic r, input logic v, input logic [31:0] inst, input logic [31:0] res);
        logic [31:0] pc;
        pc = $urandom;
        @(negedge clk);
        rst = r; ret_valid = v; ret_inst = inst; ret_pc = pc; ret_result = res;
        trace_ready = rdy_g;
        model_edge(r, v, inst, pc, res, rdy_g);
        @(posedge clk);
        #1;
        check("num_inst", {32'd0, num_inst}, {32'd0, m_cnt});
        check("output_port", {32'd0, output_port}, {32'd0, m_out});
        check("halt", {63'd0, halt}, {63'd0, m_halt});
`ifdef TRACE_FIFO_EN
        check("trace_valid", {63'd0, trace_valid}, {63'd0, (exp_q.size() > 0)});
        check("trace_data", trace_data, m_tdata);
        check("trace_ovf", {63'd0, trace_ovf}, {63'd0, m_ovf});
`endif
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic retire(input logic [31:0] inst, input logic [31:0] res);
        step(1'b0, 1'b1, inst, res);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, $urandom, $urandom);
    endtask

    initial begin
        // 1: count and result, then reset mid-stream
        do_reset();
        check("rst_num", {32'd0, num_inst}, 64'd0);
        for (int i = 1; i <= 5; i++) retire(NOP, i);
        check("tp1_num", {32'd0, num_inst}, 64'd5);
        check("tp1_out", {32'd0, output_port}, 64'd5);
        step(1'b1, 1'b1, I0, 32'h1234);
        check("tp1_rst_num", {32'd0, num_inst}, 64'd0);
        check("tp1_rst_out", {32'd0, output_port}, 64'd0);

        // 2: halt across idle cycles, then frozen
        do_reset();
        retire(I0, 32'd12);
        idle(); idle();
        retire(I1, 32'h77);
        check("tp2_halt", {63'd0, halt}, 64'd1);
        check("tp2_num", {32'd0, num_inst}, 64'd2);
        for (int i = 0; i < 3; i++) retire(NOP, $urandom);
        check("tp2_frozen_num", {32'd0, num_inst}, 64'd2);
        check("tp2_frozen_out", {32'd0, output_port}, 64'h77);

        // 3: interrupted idiom, then repeated first instruction
        do_reset();
        retire(I0, 1); retire(NOP, 2); retire(I1, 3);
        check("tp3_nohalt", {63'd0, halt}, 64'd0);
        check("tp3_num", {32'd0, num_inst}, 64'd3);
        retire(I0, 4); retire(I0, 5); retire(I1, 6);
        check("tp3_halt", {63'd0, halt}, 64'd1);

        // 4: counter wrap
        do_reset();
        @(negedge clk);
        rst = 1'b0; ret_valid = 1'b0;
        force dut.num_inst_q = 32'hFFFF_FFFE;
        #1;
        release dut.num_inst_q;
        m_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) retire(NOP, 100 + i);
        check("tp4_wrap", {32'd0, num_inst}, 64'd1);

`ifdef TRACE_FIFO_EN
        // 5: overflow with reader stalled, then in-order drain
        do_reset();
        rdy_g = 1'b0;
        for (int i = 1; i <= 9; i++) retire(NOP, i);
        check("tp5_ovf", {63'd0, trace_ovf}, 64'd1);
        check("tp5_num", {32'd0, num_inst}, 64'd9);
        rdy_g = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check("tp5_drain", {32'd0, trace_data[31:0]}, 64'(k));
            idle();
        end
        check("tp5_empty", {63'd0, trace_valid}, 64'd0);

        // 6: streaming with reader always ready
        do_reset();
        rdy_g = 1'b1;
        retire(NOP, 32'hA0);
        check("tp6_first_valid", {63'd0, trace_valid}, 64'd1);
        check("tp6_first_data", {32'd0, trace_data[31:0]}, 64'hA0);
        for (int i = 1; i < 12; i++) retire(NOP, 32'hA0 + i);
        check("tp6_ovf", {63'd0, trace_ovf}, 64'd0);
`endif

        // Random streams with occasional resets and random reader backpressure
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic [31:0] inst;
            case ($urandom_range(0, 3))
                0:       inst = I0;
                1:       inst = I1;
                2:       inst = NOP;
                default: inst = $urandom;
            endcase
            rdy_g = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 79) == 0) do_reset();
            else step(1'b0, ($urandom_range(0, 3) != 0), inst, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
